arbitro_memoria: RTL and testbench

- Shares the single-port synchronous-read program/data memory between the CPU (REM/RDM path) and an external loader/debug port.
- The CPU owns the memory by default.
- The loader obtains ownership only at an instruction boundary, while the CPU control unit is frozen through cpu_pausa.
- Sits between the REM/RDM/muxRDM path and the Memoria instance.

---
 rtl/arbitro_memoria_pkg.sv | 21 ++
 rtl/arbitro_memoria_contador_timeout.sv | 27 ++
 rtl/arbitro_memoria.sv | 138 +++++++++++++
 tb/tb_arbitro_memoria.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_memoria_pkg.sv
// Shared types and default widths for the memory arbiter between the CPU and the loader port.
package arbitro_pkg;

    localparam int unsigned LARGURA_DADOS_PADRAO = 16;
    localparam int unsigned LARGURA_END_PADRAO   = 16;

    typedef enum logic [1:0] {
        CPU_DONO,
        AGUARDA_FIM,
        EXT_DONO,
        DEVOLVE
    } estado_arbitro_t;

    // Issuer of the read whose data arrives on mem_q in the following cycle
    typedef enum logic [1:0] {
        NENHUM,
        CPU,
        EXT
    } dono_t;

endpackage

// File: rtl/arbitro_memoria_contador_timeout.sv
// Wait counter for the boundary timeout; used only when ARBITRO_TIMEOUT_EN is defined.
module contador_timeout #(
    parameter int unsigned LIMITE = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int unsigned LARGURA = $clog2(LIMITE) + 1;

    logic [LARGURA-1:0] contagem;

    // Expired flags the LIMITE-th enabled cycle since the last load
    assign expired = (contagem == LARGURA'(LIMITE - 1));

    always_ff @(posedge clk) begin
        if (reset || load) begin
            contagem <= '0;
        end else if (enable && !expired) begin
            contagem <= contagem + LARGURA'(1);
        end
    end

endmodule

// File: rtl/arbitro_memoria.sv
// Arbitrates the single-port memory between the CPU and the loader, handing over only at an
// instruction boundary. Optional boundary timeout enabled by defining ARBITRO_TIMEOUT_EN.
module arbitro_memoria
    import arbitro_pkg::*;
#(
    parameter int unsigned LARGURA_DADOS = LARGURA_DADOS_PADRAO,
    parameter int unsigned LARGURA_END   = LARGURA_END_PADRAO
`ifdef ARBITRO_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CICLOS = 64
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [LARGURA_END-1:0]   cpu_addr,
    input  logic [LARGURA_DADOS-1:0] cpu_wdata,
    input  logic                     cpu_fim_instr,
    output logic [LARGURA_DADOS-1:0] cpu_rdata,
    output logic                     cpu_rvalid,
    output logic                     cpu_pausa,
    input  logic                     ext_req,
    output logic                     ext_gnt,
    input  logic                     ext_valid,
    input  logic                     ext_we,
    input  logic [LARGURA_END-1:0]   ext_addr,
    input  logic [LARGURA_DADOS-1:0] ext_wdata,
    output logic [LARGURA_DADOS-1:0] ext_rdata,
    output logic                     ext_rvalid,
    output logic [LARGURA_END-1:0]   mem_addr,
    output logic [LARGURA_DADOS-1:0] mem_wdata,
    output logic                     mem_we,
    input  logic [LARGURA_DADOS-1:0] mem_q
`ifdef ARBITRO_TIMEOUT_EN
    ,
    output logic                     timeout_flag
`endif
);

    estado_arbitro_t estado, estado_prox;
    dono_t           leitura_dono, leitura_prox;

`ifdef ARBITRO_TIMEOUT_EN
    logic expirado;
    logic forcado;

    contador_timeout #(
        .LIMITE (TIMEOUT_CICLOS)
    ) u_contador_timeout (
        .clk     (clk),
        .reset   (reset),
        .load    (estado != AGUARDA_FIM),
        .enable  (estado == AGUARDA_FIM),
        .expired (expirado)
    );
`endif

    // Next state, memory mux and read-issuer decode
    always_comb begin
        estado_prox  = estado;
        leitura_prox = NENHUM;
        mem_addr     = cpu_addr;
        mem_wdata    = cpu_wdata;
        mem_we       = 1'b0;
`ifdef ARBITRO_TIMEOUT_EN
        forcado      = 1'b0;
`endif
        case (estado)
            CPU_DONO: begin
                mem_we = cpu_req & cpu_we;
                if (cpu_req && !cpu_we) leitura_prox = CPU;
                if (ext_req) estado_prox = AGUARDA_FIM;
            end
            AGUARDA_FIM: begin
                // CPU keeps running until it reaches the boundary
                mem_we = cpu_req & cpu_we;
                if (cpu_req && !cpu_we) leitura_prox = CPU;
                if (!ext_req) begin
                    estado_prox = CPU_DONO;
                end else if (cpu_fim_instr) begin
                    estado_prox = EXT_DONO;
`ifdef ARBITRO_TIMEOUT_EN
                end else if (expirado) begin
                    estado_prox = EXT_DONO;
                    forcado     = 1'b1;
`endif
                end
            end
            EXT_DONO: begin
                mem_addr  = ext_addr;
                mem_wdata = ext_wdata;
                mem_we    = ext_valid & ext_we;
                if (ext_valid && !ext_we) leitura_prox = EXT;
                if (!ext_req) estado_prox = DEVOLVE;
            end
            DEVOLVE: begin
                estado_prox = CPU_DONO;
            end
            default: begin
                estado_prox = CPU_DONO;
            end
        endcase
    end

    // Grant and pause follow the next state so they line up with the EXT_DONO cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            estado       <= CPU_DONO;
            leitura_dono <= NENHUM;
            ext_gnt      <= 1'b0;
            cpu_pausa    <= 1'b0;
        end else begin
            estado       <= estado_prox;
            leitura_dono <= leitura_prox;
            ext_gnt      <= (estado_prox == EXT_DONO);
            cpu_pausa    <= (estado_prox == EXT_DONO) || (estado_prox == DEVOLVE);
        end
    end

`ifdef ARBITRO_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_flag <= 1'b0;
        end else if (forcado) begin
            timeout_flag <= 1'b1;
        end else if ((estado == AGUARDA_FIM) && ext_req && cpu_fim_instr) begin
            timeout_flag <= 1'b0;
        end
    end
`endif

    assign cpu_rvalid = (leitura_dono == CPU);
    assign ext_rvalid = (leitura_dono == EXT);
    assign cpu_rdata  = mem_q;
    assign ext_rdata  = mem_q;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Bench for arbitro_memoria: directed vector table, boundary sequences and a randomized run
// against an ownership/memory reference model.
module tb_arbitro_memoria;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_fim_instr;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_rvalid, cpu_pausa;
    logic        ext_req, ext_gnt, ext_valid, ext_we;
    logic [15:0] ext_addr, ext_wdata, ext_rdata;
    logic        ext_rvalid;
    logic [15:0] mem_addr, mem_wdata, mem_q;
    logic        mem_we;
`ifdef ARBITRO_TIMEOUT_EN
    logic        timeout_flag;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arbitro_memoria dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_fim_instr (cpu_fim_instr),
        .cpu_rdata     (cpu_rdata),
        .cpu_rvalid    (cpu_rvalid),
        .cpu_pausa     (cpu_pausa),
        .ext_req       (ext_req),
        .ext_gnt       (ext_gnt),
        .ext_valid     (ext_valid),
        .ext_we        (ext_we),
        .ext_addr      (ext_addr),
        .ext_wdata     (ext_wdata),
        .ext_rdata     (ext_rdata),
        .ext_rvalid    (ext_rvalid),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_q         (mem_q)
`ifdef ARBITRO_TIMEOUT_EN
        ,
        .timeout_flag  (timeout_flag)
`endif
    );

    // Synchronous-read memory standing in for the Memoria instance
    logic [15:0] ram [0:255];
    initial for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        mem_q <= ram[mem_addr[7:0]];
    end

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp, $time);
        end
    endtask

    typedef struct {
        bit        rst;
        bit        creq;
        bit        cwe;
        bit [15:0] caddr;
        bit [15:0] cwd;
        bit        fim;
        bit        ereq;
        bit        ev;
        bit        ewe;
        bit [15:0] eaddr;
        bit [15:0] ewd;
        bit        mwe;
        bit        gnt;
        bit        pausa;
        bit        crv;
        bit        erv;
        bit [15:0] rd;
    } vec_t;

    vec_t tab[$];

    function automatic void add(bit rst, bit creq, bit cwe, bit [15:0] caddr, bit [15:0] cwd,
                                bit fim, bit ereq, bit ev, bit ewe, bit [15:0] eaddr,
                                bit [15:0] ewd, bit mwe, bit gnt, bit pausa, bit crv, bit erv,
                                bit [15:0] rd);
        tab.push_back('{rst, creq, cwe, caddr, cwd, fim, ereq, ev, ewe, eaddr, ewd,
                        mwe, gnt, pausa, crv, erv, rd});
    endfunction

    task automatic idle();
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_fim_instr = 1'b0; ext_req = 1'b0; ext_valid = 1'b0; ext_we = 1'b0;
        ext_addr = '0; ext_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: ownership, pending request, turnaround, memory image
    bit          m_ext, m_pend, m_dev;
    logic [15:0] m_mem [0:63];

    initial begin
        idle();
        // rst creq cwe caddr cwd fim ereq ev ewe eaddr ewd | mwe gnt pausa crv erv rd
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0);
        add(0, 1, 1, 16'h0010, 16'h1234, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 16'h0);
        add(0, 1, 0, 16'h0010, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'h1234);
        add(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0);
        // Boundary cycle carrying a CPU read
        add(0, 1, 0, 16'h0010, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 1, 0, 16'h1234);
        add(0, 1, 1, 16'h0020, 16'h0000, 0, 1, 1, 1, 16'h0020, 16'hBEEF, 1, 1, 1, 0, 0, 16'h0);
        add(0, 1, 1, 16'h0020, 16'h0000, 0, 1, 1, 0, 16'h0020, 16'h0000, 0, 1, 1, 0, 1, 16'hBEEF);
        add(0, 1, 1, 16'h0020, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 0, 0, 16'h0);
        add(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 0, 16'h0020, 16'h0000, 0, 1, 1, 0, 1, 16'hBEEF);
        // Release with a final loader read, then a CPU write during the turnaround
        add(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0020, 16'h0000, 0, 0, 1, 0, 1, 16'hBEEF);
        add(0, 1, 1, 16'h0020, 16'h5555, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0);
        add(0, 1, 0, 16'h0020, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'hBEEF);
        // Request withdrawn while waiting for the boundary
        add(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0);
        add(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0);
        add(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0);
        // Reset in the middle of a loader session
        add(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0);
        add(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 0, 0, 16'h0);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 0, 16'h0020, 16'h0000, 0, 0, 0, 0, 0, 16'h0);
        add(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0);

        tick();
        for (int v = 0; v < tab.size(); v++) begin
            reset = tab[v].rst; cpu_req = tab[v].creq; cpu_we = tab[v].cwe;
            cpu_addr = tab[v].caddr; cpu_wdata = tab[v].cwd; cpu_fim_instr = tab[v].fim;
            ext_req = tab[v].ereq; ext_valid = tab[v].ev; ext_we = tab[v].ewe;
            ext_addr = tab[v].eaddr; ext_wdata = tab[v].ewd;
            #1;
            chk($sformatf("v%0d mem_we", v), 32'(mem_we), 32'(tab[v].mwe));
            tick();
            chk($sformatf("v%0d ext_gnt", v), 32'(ext_gnt), 32'(tab[v].gnt));
            chk($sformatf("v%0d cpu_pausa", v), 32'(cpu_pausa), 32'(tab[v].pausa));
            chk($sformatf("v%0d cpu_rvalid", v), 32'(cpu_rvalid), 32'(tab[v].crv));
            chk($sformatf("v%0d ext_rvalid", v), 32'(ext_rvalid), 32'(tab[v].erv));
            if (tab[v].crv) chk($sformatf("v%0d cpu_rdata", v), 32'(cpu_rdata), 32'(tab[v].rd));
            if (tab[v].erv) chk($sformatf("v%0d ext_rdata", v), 32'(ext_rdata), 32'(tab[v].rd));
        end

`ifdef ARBITRO_TIMEOUT_EN
        // Boundary never arrives: grant forced after 64 waiting cycles
        idle();
        ext_req = 1'b1;
        for (int i = 0; i < 64; i++) tick();
        chk("to gnt before expiry", 32'(ext_gnt), 32'd0);
        tick();
        chk("to forced gnt", 32'(ext_gnt), 32'd1);
        chk("to forced pausa", 32'(cpu_pausa), 32'd1);
        chk("to flag set", 32'(timeout_flag), 32'd1);
        reset = 1'b1;
        tick();
        chk("to rst gnt", 32'(ext_gnt), 32'd0);
        chk("to rst pausa", 32'(cpu_pausa), 32'd0);
        chk("to rst flag", 32'(timeout_flag), 32'd0);
        chk("to rst rvalid", 32'({cpu_rvalid, ext_rvalid}), 32'd0);
        idle();
        tick();
`endif

        // Randomized run against the reference model
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_ext = 0; m_pend = 0; m_dev = 0;
        for (int i = 0; i < 64; i++) m_mem[i] = 16'h0000;
        for (int n = 0; n < 1500; n++) begin
            bit          e_crv, e_erv;
            logic [15:0] e_data;
            logic [5:0]  a;
            if ($urandom_range(7) == 0) ext_req = ~ext_req;
            cpu_fim_instr = ($urandom_range(3) == 0);
            cpu_req   = $urandom_range(1);
            cpu_we    = $urandom_range(1);
            cpu_addr  = 16'h0040 + 16'($urandom_range(63));
            cpu_wdata = 16'($urandom);
            ext_valid = $urandom_range(1);
            ext_we    = $urandom_range(1);
            ext_addr  = 16'h0040 + 16'($urandom_range(63));
            ext_wdata = 16'($urandom);

            e_crv = 0; e_erv = 0; e_data = '0;
            if (m_ext) begin
                a = ext_addr[5:0];
                if (ext_valid && ext_we) m_mem[a] = ext_wdata;
                else if (ext_valid) begin e_erv = 1; e_data = m_mem[a]; end
            end else if (!m_dev) begin
                a = cpu_addr[5:0];
                if (cpu_req && cpu_we) m_mem[a] = cpu_wdata;
                else if (cpu_req) begin e_crv = 1; e_data = m_mem[a]; end
            end
            if (m_dev) m_dev = 0;
            else if (m_ext) begin
                if (!ext_req) begin m_ext = 0; m_dev = 1; end
            end else if (m_pend) begin
                if (!ext_req) m_pend = 0;
                else if (cpu_fim_instr) begin m_pend = 0; m_ext = 1; end
            end else if (ext_req) m_pend = 1;

            tick();
            chk("rnd ext_gnt", 32'(ext_gnt), 32'(m_ext));
            chk("rnd cpu_pausa", 32'(cpu_pausa), 32'(m_ext | m_dev));
            chk("rnd cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
            chk("rnd ext_rvalid", 32'(ext_rvalid), 32'(e_erv));
            if (e_crv) chk("rnd cpu_rdata", 32'(cpu_rdata), 32'(e_data));
            if (e_erv) chk("rnd ext_rdata", 32'(ext_rdata), 32'(e_data));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
